eth_rx_hdr_parse: RTL and testbench

- Sits directly downstream of the GMII frame receiver.
- Consumes its byte-wide AXI4-Stream frame output: tdata, tvalid, tlast, tuser = bad-frame flag.
- Strips the 14-byte Ethernet header into parallel fields presented with a valid/ready handshake.
- Forwards the remaining payload bytes on a separate AXI4-Stream with full backpressure through a registered skid buffer.
- The GMII receiver has no backpressure, so a frame FIFO sits between the two whenever m-side tready can deassert.

---
 rtl/eth_rx_hdr_parse.sv | 182 ++++++++++++++++++
 tb/tb_eth_rx_hdr_parse.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_hdr_parse.sv
`default_nettype none
// ============================================================================
// Module  : eth_rx_hdr_parse
// Brief   : Splits a byte stream into Ethernet header fields + payload stream.
// Revision: 1.0 - initial release
// ============================================================================
module eth_rx_hdr_parse #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic [USER_WIDTH-1:0] m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  error_header_early_termination
);

  generate
    if (DATA_WIDTH != 8) begin : g_width_check
      $error("eth_rx_hdr_parse: DATA_WIDTH must be 8");
    end
  endgenerate

  localparam logic [3:0] c_ptr_last = 4'd13;

  typedef enum logic [0:0] {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_ptr;
  logic                  r_s_tready;
  logic                  r_hdr_valid;
  logic [47:0]           r_dest_mac;
  logic [47:0]           r_src_mac;
  logic [15:0]           r_eth_type;
  logic                  r_busy;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [USER_WIDTH-1:0] r_out_user;
  logic [DATA_WIDTH-1:0] r_tmp_data;
  logic                  r_tmp_valid;
  logic                  r_tmp_last;
  logic [USER_WIDTH-1:0] r_tmp_user;

  logic                  w_xfer;
  logic                  w_hdr_byte;
  logic                  w_pl_byte;
  logic                  w_hdr_done;
  logic                  w_hdr_valid_next;
  logic                  w_pl_ready_next;

  assign w_xfer           = s_axis_tvalid && r_s_tready;
  assign w_hdr_byte       = w_xfer && (r_state == ST_HEADER);
  assign w_pl_byte        = w_xfer && (r_state == ST_PAYLOAD);
  assign w_hdr_done       = w_hdr_byte && (r_ptr == c_ptr_last) && !s_axis_tlast;
  assign w_hdr_valid_next = (r_hdr_valid && !m_eth_hdr_ready) || w_hdr_done;
  // Conservative on current skid occupancy so a full skid is never overrun.
  assign w_pl_ready_next  = m_eth_payload_axis_tready ||
                            (!r_tmp_valid && (!r_out_valid || !s_axis_tvalid));

  always_comb begin
    w_state_next = r_state;
    if (w_hdr_done) begin
      w_state_next = ST_PAYLOAD;
    end else if (w_pl_byte && s_axis_tlast) begin
      w_state_next = ST_HEADER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HEADER;
      r_ptr       <= 4'd0;
      r_s_tready  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_dest_mac  <= 48'd0;
      r_src_mac   <= 48'd0;
      r_eth_type  <= 16'd0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hdr_valid <= w_hdr_valid_next;
      r_s_tready  <= (w_state_next == ST_HEADER) ? !w_hdr_valid_next : w_pl_ready_next;
      r_err       <= 1'b0;
      if (w_hdr_byte) begin
        if (s_axis_tlast) begin
          r_ptr  <= 4'd0;
          r_busy <= 1'b0;
          r_err  <= 1'b1;
        end else begin
          r_busy <= 1'b1;
          r_ptr  <= (r_ptr == c_ptr_last) ? 4'd0 : r_ptr + 4'd1;
          // Big-endian capture: shifting left leaves the first byte in the MSBs.
          if (r_ptr < 4'd6) begin
            r_dest_mac <= {r_dest_mac[39:0], s_axis_tdata[7:0]};
          end else if (r_ptr < 4'd12) begin
            r_src_mac <= {r_src_mac[39:0], s_axis_tdata[7:0]};
          end else begin
            r_eth_type <= {r_eth_type[7:0], s_axis_tdata[7:0]};
          end
        end
      end else if (w_pl_byte && s_axis_tlast) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Two-entry skid; the temp slot may still hold data after returning to
  // header parsing, so it is drained independently of the parser state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_user  <= '0;
      r_tmp_data  <= '0;
      r_tmp_valid <= 1'b0;
      r_tmp_last  <= 1'b0;
      r_tmp_user  <= '0;
    end else if (!r_out_valid || m_eth_payload_axis_tready) begin
      if (r_tmp_valid) begin
        r_out_data  <= r_tmp_data;
        r_out_last  <= r_tmp_last;
        r_out_user  <= r_tmp_user;
        r_out_valid <= 1'b1;
        r_tmp_valid <= w_pl_byte;
        if (w_pl_byte) begin
          r_tmp_data <= s_axis_tdata;
          r_tmp_last <= s_axis_tlast;
          r_tmp_user <= s_axis_tuser;
        end
      end else begin
        r_out_valid <= w_pl_byte;
        if (w_pl_byte) begin
          r_out_data <= s_axis_tdata;
          r_out_last <= s_axis_tlast;
          r_out_user <= s_axis_tuser;
        end
      end
    end else if (w_pl_byte) begin
      r_tmp_valid <= 1'b1;
      r_tmp_data  <= s_axis_tdata;
      r_tmp_last  <= s_axis_tlast;
      r_tmp_user  <= s_axis_tuser;
    end
  end

  assign s_axis_tready                  = r_s_tready;
  assign m_eth_hdr_valid                = r_hdr_valid;
  assign m_eth_dest_mac                 = r_dest_mac;
  assign m_eth_src_mac                  = r_src_mac;
  assign m_eth_type                     = r_eth_type;
  assign m_eth_payload_axis_tdata       = r_out_data;
  assign m_eth_payload_axis_tvalid      = r_out_valid;
  assign m_eth_payload_axis_tlast       = r_out_last;
  assign m_eth_payload_axis_tuser       = r_out_user;
  assign busy                           = r_busy;
  assign error_header_early_termination = r_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_hdr_parse.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_rx_hdr_parse
// Brief   : Directed self-checking bench for eth_rx_hdr_parse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_rx_hdr_parse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  pl_tdata;
  logic        pl_tvalid;
  logic        pl_tready;
  logic        pl_tlast;
  logic [0:0]  pl_tuser;
  logic        busy;
  logic        err_pulse;

  always #5 clk = ~clk;

  eth_rx_hdr_parse #(.DATA_WIDTH(8), .USER_WIDTH(1)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .s_axis_tdata                   (s_tdata),
    .s_axis_tvalid                  (s_tvalid),
    .s_axis_tready                  (s_tready),
    .s_axis_tlast                   (s_tlast),
    .s_axis_tuser                   (s_tuser),
    .m_eth_hdr_valid                (hdr_valid),
    .m_eth_hdr_ready                (hdr_ready),
    .m_eth_dest_mac                 (dest_mac),
    .m_eth_src_mac                  (src_mac),
    .m_eth_type                     (eth_type),
    .m_eth_payload_axis_tdata       (pl_tdata),
    .m_eth_payload_axis_tvalid      (pl_tvalid),
    .m_eth_payload_axis_tready      (pl_tready),
    .m_eth_payload_axis_tlast       (pl_tlast),
    .m_eth_payload_axis_tuser       (pl_tuser),
    .busy                           (busy),
    .error_header_early_termination (err_pulse)
  );

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
  } hdr_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } pl_t;

  hdr_t exp_hdr_q[$];
  pl_t  exp_pl_q[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int hdr_count  = 0;
  int pl_count   = 0;
  int err_count  = 0;
  int stall_seen = 0;
  bit bp_mode    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Payload sink readiness: random under backpressure, otherwise always ready.
  initial begin
    pl_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pl_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshakes are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pl_tvalid && pl_tready) begin
        pl_count++;
        if (exp_pl_q.size() == 0) begin
          check("pl_unexpected", 1, 0);
        end else begin
          pl_t e;
          e = exp_pl_q.pop_front();
          check("pl_data", pl_tdata, e.d);
          check("pl_last", pl_tlast, e.l);
          check("pl_user", pl_tuser, e.u);
        end
      end
      if (hdr_valid && hdr_ready) begin
        hdr_count++;
        if (exp_hdr_q.size() == 0) begin
          check("hdr_unexpected", 1, 0);
        end else begin
          hdr_t h;
          h = exp_hdr_q.pop_front();
          check("hdr_dest", dest_mac, h.dst);
          check("hdr_src", src_mac, h.src);
          check("hdr_type", eth_type, h.typ);
        end
      end
      if (err_pulse) err_count++;
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic last, input logic user,
                            input bit is_hdr);
    int t = 0;
    s_tdata  = b;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (is_hdr && hdr_valid) begin
        stall_seen++;
        check("hdr_stall_tready", s_tready, 0);
      end
      if (s_tready) break;
      t++;
      if (t > 2000) begin
        check("tready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // Sends the first stop_at bytes of an nbytes frame; payload byte k = base + k.
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input int nbytes, input int stop_at,
                            input logic [7:0] base, input logic user);
    if (nbytes > 14) begin
      hdr_t h;
      h.dst = dst;
      h.src = src;
      h.typ = typ;
      exp_hdr_q.push_back(h);
      for (int i = 14; i < stop_at; i++) begin
        pl_t p;
        p.d = base + 8'(i - 14);
        p.l = (i == nbytes - 1);
        p.u = (i == nbytes - 1) ? user : 1'b0;
        exp_pl_q.push_back(p);
      end
    end
    for (int i = 0; i < stop_at; i++) begin
      logic [7:0] b;
      if (i < 6)        b = dst[8*(5-i) +: 8];
      else if (i < 12)  b = src[8*(11-i) +: 8];
      else if (i == 12) b = typ[15:8];
      else if (i == 13) b = typ[7:0];
      else              b = base + 8'(i - 14);
      drive_byte(b, (i == nbytes - 1), (i == nbytes - 1) ? user : 1'b0, (i < 14));
      if (i == 13 && nbytes > 14) check("busy_in_frame", busy, 1);
    end
    if (stop_at == nbytes) check("busy_after_last", busy, 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_hdr_q.size() != 0 || exp_pl_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", (t < 2000), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int h0, p0, e0;

  initial begin
    rst_n     = 1'b0;
    s_tdata   = 8'h00;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_tuser   = 1'b0;
    hdr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", s_tready, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_dest", dest_mac, 0);
    check("rst_src", src_mac, 0);
    check("rst_type", eth_type, 0);
    check("rst_pl_valid", {pl_tvalid, pl_tlast, pl_tuser, pl_tdata}, 0);
    check("rst_busy_err", {busy, err_pulse}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", s_tready, 1);
    @(posedge clk);
    #1;

    // Minimum-size frame, good
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    send_frame(48'h020000000001, 48'h020000000002, 16'h0800, 60, 60, 8'h00, 1'b0);
    wait_drain();
    check("t1_hdr_cnt", hdr_count - h0, 1);
    check("t1_pl_cnt", pl_count - p0, 46);
    check("t1_err_cnt", err_count - e0, 0);

    // Same frame flagged bad
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    send_frame(48'h020000000001, 48'h020000000002, 16'h0800, 60, 60, 8'h00, 1'b1);
    wait_drain();
    check("t2_hdr_cnt", hdr_count - h0, 1);
    check("t2_pl_cnt", pl_count - p0, 46);
    check("t2_err_cnt", err_count - e0, 0);

    // Runt followed by a good frame
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    send_frame(48'h111111111111, 48'h222222222222, 16'h3333, 10, 10, 8'h00, 1'b0);
    send_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h86DD, 34, 34, 8'hA0, 1'b0);
    wait_drain();
    check("t3_hdr_cnt", hdr_count - h0, 1);
    check("t3_pl_cnt", pl_count - p0, 20);
    check("t3_err_cnt", err_count - e0, 1);

    // Header-only frame terminated on byte 13
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    send_frame(48'hAABBCCDDEEFF, 48'h010203040506, 16'h0806, 14, 14, 8'h00, 1'b0);
    wait_drain();
    check("t4_hdr_cnt", hdr_count - h0, 0);
    check("t4_pl_cnt", pl_count - p0, 0);
    check("t4_err_cnt", err_count - e0, 1);

    // Backpressure on both outputs across back-to-back frames
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    stall_seen = 0;
    bp_mode    = 1'b1;
    hdr_ready  = 1'b0;
    fork
      begin
        send_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h1234, 15, 15, 8'h55, 1'b0);
        send_frame(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h8100, 24, 24, 8'hF8, 1'b1);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        hdr_ready = 1'b1;
      end
    join
    wait_drain();
    bp_mode = 1'b0;
    check("t5_hdr_cnt", hdr_count - h0, 2);
    check("t5_pl_cnt", pl_count - p0, 11);
    check("t5_err_cnt", err_count - e0, 0);
    check("t5_stall_seen", (stall_seen > 0), 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of the payload
    send_frame(48'hC0FFEE000001, 48'hDEADBEEF0002, 16'h0800, 60, 34, 8'h40, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hdr_valid", hdr_valid, 0);
    check("mid_rst_pl_valid", pl_tvalid, 0);
    check("mid_rst_tready", s_tready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dest", dest_mac, 0);
    exp_hdr_q.delete();
    exp_pl_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    h0 = hdr_count; p0 = pl_count; e0 = err_count;
    send_frame(48'h020000000003, 48'h020000000004, 16'h88CC, 64, 64, 8'h10, 1'b0);
    wait_drain();
    check("t6_hdr_cnt", hdr_count - h0, 1);
    check("t6_pl_cnt", pl_count - p0, 50);
    check("t6_err_cnt", err_count - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
